// File: rtl/fetch_unit_pkg.sv
// Shared front-end types: fetch FSM states, IF/ID payload and XLEN/NOP constants.
// Also used by the hazard-detection and decode stages.
package fetch_unit_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FETCH    = 2'd1,
        ST_STALL    = 2'd2,
        ST_REDIRECT = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            valid;
    } if_id_t;

    function automatic logic [XLEN-1:0] pc_incr(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register. Priority: bubble > hold > load; with no control asserted it keeps its value.
module if_id_reg
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   load_i,
    input  logic   hold_i,
    input  logic   bubble_i,
    input  if_id_t data_i,
    output if_id_t q_o
);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            q_o.pc    <= '0;
            q_o.instr <= NOP_INSTR;
            q_o.valid <= 1'b0;
        end else if (bubble_i) begin
            q_o.pc    <= '0;
            q_o.instr <= NOP_INSTR;
            q_o.valid <= 1'b0;
        end else if (!hold_i && load_i) begin
            q_o <= data_i;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, request FSM, one-entry skid buffer and
// pending-redirect target, feeding the IF/ID register.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            PCWrite_i,
    input  logic            Stall_i,
    input  logic            Flush_i,
    input  logic [XLEN-1:0] branch_target_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ack_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] instr_o,
    output logic            valid_o
);

    fetch_state_e    state_q, state_n;
    logic [XLEN-1:0] pc_q, pc_n;
    logic [XLEN-1:0] skid_q, skid_n;
    logic [XLEN-1:0] target_q, target_n;
    logic            req_n;
    logic [XLEN-1:0] addr_n;

    logic            go_c;
    fetch_state_e    run_state_c;
    logic            ifid_load_c, ifid_hold_c, ifid_bubble_c;
    if_id_t          ifid_d_c, ifid_q;

    // Next-state, PC and IF/ID control decode; Flush_i wins over Stall_i/PCWrite_i everywhere.
    always_comb begin
        state_n        = state_q;
        pc_n           = pc_q;
        skid_n         = skid_q;
        target_n       = target_q;
        ifid_load_c    = 1'b0;
        ifid_hold_c    = 1'b0;
        ifid_bubble_c  = 1'b0;
        ifid_d_c.pc    = pc_q;
        ifid_d_c.instr = imem_rdata_i;
        ifid_d_c.valid = 1'b1;
        go_c           = !Stall_i && PCWrite_i;
        // After a completed fetch, drop to IDLE once fetch is disabled.
        run_state_c    = start_i ? ST_FETCH : ST_IDLE;

        case (state_q)
            ST_IDLE: begin
                if (Flush_i) pc_n = branch_target_i;
                if (start_i) state_n = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ack_i) begin
                    if (Flush_i) begin
                        ifid_bubble_c = 1'b1;
                        pc_n          = branch_target_i;
                        state_n       = run_state_c;
                    end else if (go_c) begin
                        ifid_load_c = 1'b1;
                        pc_n        = pc_incr(pc_q);
                        state_n     = run_state_c;
                    end else begin
                        skid_n      = imem_rdata_i;
                        ifid_hold_c = 1'b1;
                        state_n     = ST_STALL;
                    end
                end else if (Flush_i) begin
                    target_n      = branch_target_i;
                    ifid_bubble_c = 1'b1;
                    state_n       = ST_REDIRECT;
                end else if (Stall_i) begin
                    ifid_hold_c = 1'b1;
                end else begin
                    ifid_bubble_c = 1'b1;
                end
            end
            ST_STALL: begin
                if (Flush_i) begin
                    ifid_bubble_c = 1'b1;
                    skid_n        = '0;
                    pc_n          = branch_target_i;
                    state_n       = run_state_c;
                end else if (go_c) begin
                    ifid_d_c.instr = skid_q;
                    ifid_load_c    = 1'b1;
                    skid_n         = '0;
                    pc_n           = pc_incr(pc_q);
                    state_n        = run_state_c;
                end else begin
                    ifid_hold_c = 1'b1;
                end
            end
            ST_REDIRECT: begin
                // Old request stays up; its data is dropped when it finally returns.
                ifid_bubble_c = 1'b1;
                if (Flush_i) target_n = branch_target_i;
                if (imem_ack_i) begin
                    pc_n    = Flush_i ? branch_target_i : target_q;
                    state_n = run_state_c;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        req_n  = (state_n == ST_FETCH) || (state_n == ST_REDIRECT);
        addr_n = (state_n == ST_REDIRECT) ? imem_addr_o : pc_n;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            skid_q      <= '0;
            target_q    <= '0;
            imem_req_o  <= 1'b0;
            imem_addr_o <= RESET_PC;
        end else begin
            state_q     <= state_n;
            pc_q        <= pc_n;
            skid_q      <= skid_n;
            target_q    <= target_n;
            imem_req_o  <= req_n;
            imem_addr_o <= addr_n;
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (ifid_load_c),
        .hold_i   (ifid_hold_c),
        .bubble_i (ifid_bubble_c),
        .data_i   (ifid_d_c),
        .q_o      (ifid_q)
    );

    assign pc_o    = ifid_q.pc;
    assign instr_o = ifid_q.instr;
    assign valid_o = ifid_q.valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, stall/skid, flush with and
// without ack, flush+stall, mid-request reset, start drop and IDLE flush.
module tb_fetch_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        PCWrite_i;
    logic        Stall_i;
    logic        Flush_i;
    logic [31:0] branch_target_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] pc_o;
    logic [31:0] instr_o;
    logic        valid_o;

    int total = 0;
    int bad   = 0;

    fetch_unit dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .start_i         (start_i),
        .PCWrite_i       (PCWrite_i),
        .Stall_i         (Stall_i),
        .Flush_i         (Flush_i),
        .branch_target_i (branch_target_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_ack_i      (imem_ack_i),
        .imem_rdata_i    (imem_rdata_i),
        .pc_o            (pc_o),
        .instr_o         (instr_o),
        .valid_o         (valid_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h want %08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i           = 1'b0;
        start_i         = 1'b0;
        PCWrite_i       = 1'b1;
        Stall_i         = 1'b0;
        Flush_i         = 1'b0;
        branch_target_i = 32'h0;
        imem_ack_i      = 1'b0;
        imem_rdata_i    = 32'h0;

        tick();
        chk("rst_req",   32'(imem_req_o), 32'd0);
        chk("rst_addr",  imem_addr_o,     32'h0);
        chk("rst_pc",    pc_o,            32'h0);
        chk("rst_instr", instr_o,         32'h13);
        chk("rst_valid", 32'(valid_o),    32'd0);

        // sequential fetch, ack every cycle
        rst_i = 1'b1; start_i = 1'b1; imem_ack_i = 1'b1; imem_rdata_i = 32'h00A0_0093;
        tick();
        chk("start_req",   32'(imem_req_o), 32'd1);
        chk("start_addr",  imem_addr_o,     32'h0);
        chk("start_valid", 32'(valid_o),    32'd0);
        tick();
        chk("seq0_pc",    pc_o,         32'h0);
        chk("seq0_instr", instr_o,      32'h00A0_0093);
        chk("seq0_valid", 32'(valid_o), 32'd1);
        chk("seq0_addr",  imem_addr_o,  32'h4);
        tick();
        chk("seq1_pc",   pc_o,        32'h4);
        chk("seq1_addr", imem_addr_o, 32'h8);

        // stall two cycles while PC=8 is acked: data goes to skid
        imem_rdata_i = 32'hAAAA_0008; Stall_i = 1'b1; PCWrite_i = 1'b0;
        tick();
        chk("stall0_pc",  pc_o,            32'h4);
        chk("stall0_req", 32'(imem_req_o), 32'd0);
        imem_rdata_i = 32'hDEAD_BEEF;
        tick();
        chk("stall1_pc",  pc_o,            32'h4);
        chk("stall1_req", 32'(imem_req_o), 32'd0);
        Stall_i = 1'b0; PCWrite_i = 1'b1;
        tick();
        chk("skid_pc",    pc_o,            32'h8);
        chk("skid_instr", instr_o,         32'hAAAA_0008);
        chk("skid_valid", 32'(valid_o),    32'd1);
        chk("skid_addr",  imem_addr_o,     32'hC);
        chk("skid_req",   32'(imem_req_o), 32'd1);

        // flush together with ack
        imem_rdata_i = 32'h1111_1111; Flush_i = 1'b1; branch_target_i = 32'h100;
        tick();
        chk("fl_ack_instr", instr_o,     32'h13);
        chk("fl_ack_valid", 32'(valid_o), 32'd0);
        chk("fl_ack_addr",  imem_addr_o, 32'h100);
        Flush_i = 1'b0; imem_rdata_i = 32'h2222_2222;
        tick();
        chk("tgt_pc",    pc_o,         32'h100);
        chk("tgt_instr", instr_o,      32'h2222_2222);
        chk("tgt_addr",  imem_addr_o,  32'h104);

        // flush while ack delayed three cycles
        imem_ack_i = 1'b0; Flush_i = 1'b1; branch_target_i = 32'h200; imem_rdata_i = 32'h3333_3333;
        tick();
        chk("redir0_req",   32'(imem_req_o), 32'd1);
        chk("redir0_addr",  imem_addr_o,     32'h104);
        chk("redir0_valid", 32'(valid_o),    32'd0);
        Flush_i = 1'b0; branch_target_i = 32'h0;
        tick();
        chk("redir1_addr", imem_addr_o, 32'h104);
        tick();
        chk("redir2_addr",  imem_addr_o,  32'h104);
        chk("redir2_valid", 32'(valid_o), 32'd0);
        imem_ack_i = 1'b1;
        tick();
        chk("redir_ack_addr",  imem_addr_o,     32'h200);
        chk("redir_ack_req",   32'(imem_req_o), 32'd1);
        chk("redir_ack_valid", 32'(valid_o),    32'd0);
        chk("redir_ack_instr", instr_o,         32'h13);
        imem_rdata_i = 32'h4444_4444;
        tick();
        chk("redir_pc",    pc_o,         32'h200);
        chk("redir_instr", instr_o,      32'h4444_4444);
        chk("redir_valid", 32'(valid_o), 32'd1);

        // flush and stall together: flush wins
        Flush_i = 1'b1; Stall_i = 1'b1; PCWrite_i = 1'b0; branch_target_i = 32'h300; imem_rdata_i = 32'h5555_5555;
        tick();
        chk("flst_valid", 32'(valid_o), 32'd0);
        chk("flst_addr",  imem_addr_o,  32'h300);
        chk("flst_instr", instr_o,      32'h13);
        Flush_i = 1'b0; Stall_i = 1'b0; PCWrite_i = 1'b1; imem_rdata_i = 32'h6666_6666;
        tick();
        chk("after_flst_pc", pc_o,        32'h300);
        chk("after_flst_addr", imem_addr_o, 32'h304);

        // no ack: hold under stall, bubble otherwise
        imem_ack_i = 1'b0; Stall_i = 1'b1;
        tick();
        chk("noack_hold_valid", 32'(valid_o), 32'd1);
        chk("noack_hold_pc",    pc_o,         32'h300);
        Stall_i = 1'b0;
        tick();
        chk("noack_bub_valid", 32'(valid_o),    32'd0);
        chk("noack_bub_req",   32'(imem_req_o), 32'd1);
        chk("noack_bub_addr",  imem_addr_o,     32'h304);

        // reset during pending request
        rst_i = 1'b0;
        #2;
        chk("mrst_req",   32'(imem_req_o), 32'd0);
        chk("mrst_addr",  imem_addr_o,     32'h0);
        chk("mrst_valid", 32'(valid_o),    32'd0);
        chk("mrst_pc",    pc_o,            32'h0);
        start_i = 1'b0; imem_ack_i = 1'b1; imem_rdata_i = 32'h7777_7777;
        tick();
        rst_i = 1'b1;
        tick();
        chk("idle_ack_req",   32'(imem_req_o), 32'd0);
        chk("idle_ack_valid", 32'(valid_o),    32'd0);
        start_i = 1'b1;
        tick();
        chk("restart_req",   32'(imem_req_o), 32'd1);
        chk("restart_addr",  imem_addr_o,     32'h0);
        chk("restart_valid", 32'(valid_o),    32'd0);
        tick();
        chk("restart_instr", instr_o, 32'h7777_7777);

        // drop start with a request outstanding
        start_i = 1'b0; imem_ack_i = 1'b0;
        tick();
        chk("drop_req", 32'(imem_req_o), 32'd1);
        imem_ack_i = 1'b1; imem_rdata_i = 32'h8888_8888;
        tick();
        chk("drop_ack_pc",    pc_o,            32'h4);
        chk("drop_ack_instr", instr_o,         32'h8888_8888);
        chk("drop_ack_req",   32'(imem_req_o), 32'd0);
        chk("drop_ack_addr",  imem_addr_o,     32'h8);

        // flush in IDLE only moves the PC
        imem_ack_i = 1'b0; Flush_i = 1'b1; branch_target_i = 32'h400;
        tick();
        chk("idle_fl_req",  32'(imem_req_o), 32'd0);
        chk("idle_fl_addr", imem_addr_o,     32'h400);
        Flush_i = 1'b0; start_i = 1'b1;
        tick();
        chk("idle_fl_start_req",  32'(imem_req_o), 32'd1);
        chk("idle_fl_start_addr", imem_addr_o,     32'h400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
